// File: rtl/bram_sp_initiator.sv
// bram_sp_initiator
//   Request-side controller for one single-port block RAM wrapper. Accepts
//   read/write requests on a valid/ready stream, drives the wrapper pins
//   combinationally from the accepted request, tracks the fixed read latency
//   and returns read data in order through a credit-limited response FIFO.
//
//   Build option: define BRAM_SP_INITIATOR_OUTREG_EN to register bram_data_out
//   before capture (read latency L=2, FIFO depth 4). Default: L=1, depth 3.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   req_valid/ready/write/addr/data   request stream, addr = {block, word}
//   rsp_valid/ready/data              in-order read response stream
//   bram_enable/write/block/addr/data_in   drive to wrapper
//   bram_data_out                          read data from wrapper
module bram_sp_initiator #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned BLOCK_W = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [BLOCK_W+ADDR_W-1:0]  req_addr,
   input  logic [WIDTH-1:0]           req_data,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_data,
   output logic                       bram_enable,
   output logic                       bram_write,
   output logic [BLOCK_W-1:0]         bram_block,
   output logic [ADDR_W-1:0]          bram_addr,
   output logic [WIDTH-1:0]           bram_data_in,
   input  logic [WIDTH-1:0]           bram_data_out
);

`ifdef BRAM_SP_INITIATOR_OUTREG_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif
   localparam int unsigned DEPTH = LAT + 2;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned AW    = BLOCK_W + ADDR_W;

   logic [CNT_W-1:0] count, count_n;
   logic [CNT_W-1:0] fill, fill_n;
   logic [PTR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
   logic [WIDTH-1:0] mem [2**PTR_W];
   logic [WIDTH-1:0] head_n;
   logic [WIDTH-1:0] cap_data;
   logic [LAT-1:0]   rd_vld;
   logic             accept, accept_rd, push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit gate: depends only on reset and the credit counter.
   assign req_ready = !rst && (count < CNT_W'(DEPTH));
   assign accept    = req_valid && req_ready;
   assign accept_rd = accept && !req_write;
   assign pop       = rsp_valid && rsp_ready;
   assign push      = rd_vld[LAT-1];

   // Wrapper pins follow the request directly so the RAM samples on the accept edge.
   assign bram_enable  = accept;
   assign bram_write   = accept && req_write;
   assign bram_block   = req_addr[AW-1 -: BLOCK_W];
   assign bram_addr    = req_addr[ADDR_W-1:0];
   assign bram_data_in = req_data;

   // Read-latency tracking and data capture point.
`ifdef BRAM_SP_INITIATOR_OUTREG_EN
   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) data_q <= '0;
      else     data_q <= bram_data_out;
   end

   assign cap_data = data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_vld <= '0;
      else     rd_vld <= {rd_vld[0], accept_rd};
   end
`else
   assign cap_data = bram_data_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_vld <= '0;
      else     rd_vld <= accept_rd;
   end
`endif

   // Next-state for credits, FIFO pointers and the registered head.
   always_comb begin
      count_n  = count;
      fill_n   = fill;
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      head_n   = rsp_data;

      case ({accept_rd, pop})
         2'b10:   count_n = count + 1'b1;
         2'b01:   count_n = count - 1'b1;
         default: ;
      endcase

      case ({push, pop})
         2'b10:   fill_n = fill + 1'b1;
         2'b01:   fill_n = fill - 1'b1;
         default: ;
      endcase

      if (push) wr_ptr_n = ptr_inc(wr_ptr);
      if (pop)  rd_ptr_n = ptr_inc(rd_ptr);

      // Pushed word becomes head when the FIFO is (or is about to be) empty,
      // since it is not yet in storage to be read back.
      if (push && ((fill == '0) || ((fill == CNT_W'(1)) && pop)))
         head_n = cap_data;
      else if (pop && (fill_n != '0))
         head_n = mem[rd_ptr_n];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         fill      <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         count     <= count_n;
         fill      <= fill_n;
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         rsp_valid <= (fill_n != '0);
         rsp_data  <= head_n;
      end
   end

   // FIFO storage; contents are don't-care after reset since pointers restart.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cap_data;
   end

   // Credits make overflow impossible; catch it if that ever breaks.
   always @(posedge clk) begin
      if (!rst)
         assert (!(push && !pop && (fill == CNT_W'(DEPTH))))
            else $error("bram_sp_initiator: push into full response fifo");
   end

endmodule

// File: tb/tb_bram_sp_initiator.sv
// tb_bram_sp_initiator
//   Self-checking bench for bram_sp_initiator. A behavioural single-port RAM
//   stands in for the wrapper; a reference model (flat memory + expected
//   response queue, updated on each accepted request) predicts responses,
//   credit state and pin decode. Honours BRAM_SP_INITIATOR_OUTREG_EN.
module tb_bram_sp_initiator;

`ifdef BRAM_SP_INITIATOR_OUTREG_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif
   localparam int D = L + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [13:0] req_addr;
   logic [7:0]  req_data;
   logic        rsp_valid, rsp_ready;
   logic [7:0]  rsp_data;
   logic        bram_enable, bram_write;
   logic [2:0]  bram_block;
   logic [10:0] bram_addr;
   logic [7:0]  bram_data_in, bram_data_out;

   bram_sp_initiator #(.WIDTH(8), .ADDR_W(11), .BLOCK_W(3)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .bram_enable(bram_enable), .bram_write(bram_write), .bram_block(bram_block),
      .bram_addr(bram_addr), .bram_data_in(bram_data_in), .bram_data_out(bram_data_out)
   );

   always #5 clk = ~clk;

   // Wrapper stand-in: synchronous RAM, write-first on data_out.
   logic [7:0] bram_mem [16384];
   always @(posedge clk) begin
      if (bram_enable) begin
         if (bram_write) begin
            bram_mem[{bram_block, bram_addr}] <= bram_data_in;
            bram_data_out <= bram_data_in;
         end else begin
            bram_data_out <= bram_mem[{bram_block, bram_addr}];
         end
      end
   end

   // Reference model state.
   logic [7:0] ref_mem [16384];
   logic [7:0] exp_q[$];
   logic [7:0] pop_log[$];
   bit         acc, popped;
   int         n_cmp = 0;
   int         n_bad = 0;

   typedef struct {
      bit          rst, valid, write, rsp_rdy;
      logic [13:0] addr;
      logic [7:0]  data;
      bit          e_ready, e_en, e_wr;
      logic [2:0]  e_block;
      logic [10:0] e_addr;
      bit          e_rvalid, chk_data;
      logic [7:0]  e_rdata;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle check at the negedge, then fold this cycle's handshakes into the model.
   task automatic monitor();
      acc = 1'b0;
      popped = 1'b0;
      if (rst) begin
         chk("rst_req_ready", 32'(req_ready), 0);
         chk("rst_rsp_valid", 32'(rsp_valid), 0);
         chk("rst_bram_enable", 32'(bram_enable), 0);
         exp_q.delete();
         return;
      end
      chk("req_ready_credit", 32'(req_ready), 32'(exp_q.size() < D));
      acc = req_valid && req_ready;
      if (acc) begin
         chk("bram_enable", 32'(bram_enable), 1);
         chk("bram_write", 32'(bram_write), 32'(req_write));
         chk("bram_block", 32'(bram_block), 32'(req_addr[13:11]));
         chk("bram_addr", 32'(bram_addr), 32'(req_addr[10:0]));
         if (req_write) chk("bram_data_in", 32'(bram_data_in), 32'(req_data));
      end else begin
         chk("idle_bram_enable", 32'(bram_enable), 0);
         chk("idle_bram_write", 32'(bram_write), 0);
      end
      if (exp_q.size() == 0) chk("rsp_valid_nothing_pending", 32'(rsp_valid), 0);
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
         chk("rsp_data_order", 32'(rsp_data), 32'(exp_q[0]));
         pop_log.push_back(rsp_data);
         void'(exp_q.pop_front());
         popped = 1'b1;
      end
      if (acc) begin
         if (req_write) ref_mem[req_addr] = req_data;
         else           exp_q.push_back(ref_mem[req_addr]);
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
      monitor();
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit w, input logic [13:0] a, input logic [7:0] d);
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_data  = d;
   endtask

   task automatic drain(input int n);
      drive(0, 0, 14'd0, 8'd0);
      rsp_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         to_neg();
         to_pos();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nacc, nxt, npop, first, last;
      logic [7:0] v1, v2;

      rst = 1'b1;
      rsp_ready = 1'b0;
      bram_data_out = 8'd0;
      drive(0, 0, 14'd0, 8'd0);
      for (int i = 0; i < 16384; i++) begin
         bram_mem[i] = 8'($urandom);
         ref_mem[i]  = bram_mem[i];
      end

      // Reset state, then write/read-after-write latency.
      vecs[0] = '{1,1,0,0, 14'd0, 8'h00,          0,0,0, 3'd0,0,           0,        1,        8'h00};
      vecs[1] = '{0,1,1,1, {3'd2,11'h010}, 8'hA5, 1,1,1, 3'd2,11'h010,     0,        0,        8'h00};
      vecs[2] = '{0,1,0,1, {3'd2,11'h010}, 8'h00, 1,1,0, 3'd2,11'h010,     0,        0,        8'h00};
      vecs[3] = '{0,0,0,1, 14'd0, 8'h00,          1,0,0, 3'd0,0,           0,        0,        8'h00};
      vecs[4] = '{0,0,0,1, 14'd0, 8'h00,          1,0,0, 3'd0,0,           (L == 1), (L == 1), 8'hA5};
      vecs[5] = '{0,0,0,1, 14'd0, 8'h00,          1,0,0, 3'd0,0,           (L == 2), (L == 2), 8'hA5};
      vecs[6] = '{0,0,0,1, 14'd0, 8'h00,          1,0,0, 3'd0,0,           0,        0,        8'h00};
      for (int i = 0; i < 7; i++) begin
         rst = vecs[i].rst;
         rsp_ready = vecs[i].rsp_rdy;
         drive(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].data);
         to_neg();
         chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
         chk($sformatf("vec%0d_bram_enable", i), 32'(bram_enable), 32'(vecs[i].e_en));
         chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rvalid));
         if (vecs[i].e_en) begin
            chk($sformatf("vec%0d_bram_write", i), 32'(bram_write), 32'(vecs[i].e_wr));
            chk($sformatf("vec%0d_bram_block", i), 32'(bram_block), 32'(vecs[i].e_block));
            chk($sformatf("vec%0d_bram_addr", i), 32'(bram_addr), 32'(vecs[i].e_addr));
         end
         if (vecs[i].chk_data)
            chk($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_rdata));
         to_pos();
      end

      // Backpressure: preload 0x10..0x14, then credit-limited reads.
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 14'(i), 8'(8'h10 + i));
         to_neg();
         to_pos();
      end
      drain(2);
      rsp_ready = 1'b0;
      pop_log.delete();
      nacc = 0;
      for (int c = 0; c < 8; c++) begin
         drive(1, 0, 14'(nacc), 8'd0);
         to_neg();
         if (acc) nacc++;
         to_pos();
      end
      chk("bp_accepted", 32'(nacc), 32'(D));
      chk("bp_req_ready_low", 32'(req_ready), 0);
      rsp_ready = 1'b1;
      for (int c = 0; c < 30 && pop_log.size() < 5; c++) begin
         drive(nacc < 5, 0, 14'(nacc), 8'd0);
         to_neg();
         if (c == 0) chk("bp_ready_before_pop", 32'(req_ready), 0);
         if (c == 1) chk("bp_ready_after_pop", 32'(req_ready), 1);
         if (acc) nacc++;
         to_pos();
      end
      chk("bp_pop_count", 32'(pop_log.size()), 5);
      for (int i = 0; i < 5 && i < pop_log.size(); i++)
         chk($sformatf("bp_pop%0d", i), 32'(pop_log[i]), 32'(8'h10 + i));

      // Streaming: 16 back-to-back reads.
      drain(3);
      nacc = 0; npop = 0; first = -1; last = -1;
      for (int c = 0; c < 40 && npop < 16; c++) begin
         drive(nacc < 16, 0, 14'($urandom), 8'd0);
         to_neg();
         if (nacc < 16) chk("stream_req_ready", 32'(req_ready), 1);
         if (acc) nacc++;
         if (popped) begin
            if (first < 0) first = c;
            last = c;
            npop++;
         end
         to_pos();
      end
      chk("stream_pops", 32'(npop), 16);
      chk("stream_consecutive", 32'(last - first), 15);

      // Interleaved W/R/W/R at the address-space corners.
      drain(2);
      pop_log.delete();
      v1 = 8'($urandom);
      v2 = 8'($urandom) ^ 8'h5A;
      drive(1, 1, {3'd7, 11'h7FF}, v1); to_neg(); to_pos();
      drive(1, 0, {3'd7, 11'h7FF}, 8'd0); to_neg(); to_pos();
      drive(1, 1, 14'd0, v2); to_neg(); to_pos();
      drive(1, 0, 14'd0, 8'd0); to_neg(); to_pos();
      drain(6);
      chk("wr_rd_pop_count", 32'(pop_log.size()), 2);
      if (pop_log.size() == 2) begin
         chk("wr_rd_blk7", 32'(pop_log[0]), 32'(v1));
         chk("wr_rd_blk0", 32'(pop_log[1]), 32'(v2));
      end

      // Asynchronous reset with two reads in flight.
      rsp_ready = 1'b0;
      drive(1, 0, 14'd3, 8'd0); to_neg(); to_pos();
      drive(1, 0, 14'd4, 8'd0); to_neg(); to_pos();
      drive(0, 0, 14'd0, 8'd0);
      #2 rst = 1'b1;
      to_neg(); to_pos();
      to_neg(); to_pos();
      rst = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         to_neg();
         chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
         to_pos();
      end
      rsp_ready = 1'b0;
      nacc = 0;
      for (int c = 0; c < D + 2; c++) begin
         drive(1, 0, 14'(c), 8'd0);
         to_neg();
         if (acc) nacc++;
         to_pos();
      end
      chk("post_rst_credits", 32'(nacc), 32'(D));
      drain(10);

      // Randomized traffic on a small address set to provoke read-after-write.
      drive(0, 0, 14'd0, 8'd0);
      for (int c = 0; c < 400; c++) begin
         if (!req_valid || acc) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom);
            req_addr  = {3'($urandom), ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 3))};
            req_data  = 8'($urandom);
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         to_neg();
         to_pos();
      end
      drain(12);
      chk("final_queue_empty", 32'(exp_q.size()), 0);
      chk("final_rsp_valid", 32'(rsp_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bram_sp_initiator.md
# bram_sp_initiator

Request-side controller for one single-port block RAM wrapper: it accepts read/write requests on a valid/ready stream and drives the wrapper's enable, write, block, address and data pins. It tracks the fixed read latency, captures read data in a credit-limited response FIFO, and returns it in order on a valid/ready response stream. It sits between a bus-side master (CPU bridge, DMA engine) and the `bramwrapper_singleport` instances behind it.

## Interface
Parameters:
- `WIDTH`, 8: data width; must match the wrapper's `WIDTH`.
- `ADDR_W`, 11: word address width inside one block.
- `BLOCK_W`, 3: block-select width.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on an edge where both are high.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  BLOCK_W+ADDR_W  {block, word address}.
- `req_data`  in  WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes `rsp_data` on an edge where both are high.
- `rsp_data`  out  WIDTH  read data, in request order.
- `bram_enable`  out  1  to wrapper `enable`.
- `bram_write`  out  1  to wrapper `write`.
- `bram_block`  out  BLOCK_W  to wrapper `block`.
- `bram_addr`  out  ADDR_W  to wrapper `addr`.
- `bram_data_in`  out  WIDTH  to wrapper `data_in`.
- `bram_data_out`  in  WIDTH  from wrapper `data_out`.

## Operation
- Latency L = 1 (2 with the macro below); FIFO depth and credit limit D = L+2.
- `count` (0..D): reads accepted but not yet popped from `rsp`. Accepting a read adds 1, a `rsp` pop subtracts 1, both in one cycle leaves `count` unchanged.
- `req_ready` = !rst && count < D. It is registered-state only, with no combinational path from `req_valid` or `rsp_ready`. Writes also wait on `req_ready` but consume no credit.
- BRAM pins are combinational from the request: `bram_enable` = req_valid && req_ready; `bram_write` = enable && req_write; `bram_block` = req_addr[top BLOCK_W]; `bram_addr` = req_addr[ADDR_W-1:0]; `bram_data_in` = req_data.
- The read pipeline is a valid-bit shift register of length L, loaded with (accept && !req_write). When the last stage is set, `bram_data_out` (or its registered copy in the OUTREG build) is pushed into the FIFO.
- Writes produce no response.
- Credits guarantee the FIFO never overflows; a push into a full FIFO is a design error and is asserted against in simulation.
- `rsp_valid` = FIFO not empty; `rsp_data` = FIFO head, registered.
- FIFO pointers wrap modulo D.
- Read-after-write to the same address on consecutive accepts returns the new data (wrapper normal-write, bypass-read).

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `count`=0, pipeline valids=0, FIFO empty. `bram_enable`=0 and `bram_write`=0 because `req_ready`=0.
- Read accepted at edge E0. The wrapper samples at E0, data is valid after E0, and it is pushed at E1 (E2 with OUTREG). `rsp_valid` is high from E1+ (E2+).
- Sustained throughput with `rsp_ready`=1 is one request per cycle, reads and writes mixed freely.
- With `rsp_ready`=0, at most D reads are accepted, then `req_ready` drops. It rises one cycle after the first pop.
- Reset mid-operation discards in-flight and buffered reads. No `rsp_valid` may appear after release for pre-reset requests.
- Simultaneous push and pop on a non-empty FIFO: head advances, occupancy unchanged. Simultaneous push and pop on an empty FIFO cannot occur because pop requires `rsp_valid`.

## Configuration
- `BRAM_SP_INITIATOR_OUTREG_EN` defined: adds one register stage on `bram_data_out` (relieves BRAM clock-to-out); L=2, D=4, and read latency is 3 edges accept-to-`rsp_valid`.
- Undefined: data is captured directly from `bram_data_out`; L=1, D=3, and read latency is 2 edges.

## Test plan
- Reset: assert `rst` with `req_valid`=1 -> `req_ready`=0, `bram_enable`=0, `rsp_valid`=0, `rsp_data`=0x00.
- Write 0xA5 to {block 2, addr 0x010}, then read the same address on the next cycle -> `rsp_data`=0xA5 with `rsp_valid` high 2 edges (3 with OUTREG) after the read accept.
- Backpressure: `rsp_ready`=0, offer 5 reads of addrs 0..4 holding 0x10..0x14 -> 3 (4) accepted, `req_ready`=0. Release -> 0x10, 0x11, 0x12(, 0x13) in order, then the remaining reads resume.
- Streaming: 16 back-to-back reads with `rsp_ready`=1 -> `req_ready` never drops and 16 responses arrive on consecutive cycles in order.
- Interleaved W/R/W/R to block 7 addr 0x7FF, then block 0 addr 0 -> exactly 2 responses carrying the just-written values, and `bram_block`/`bram_addr` decode matches each request.
- Reset asserted asynchronously with 2 reads in flight -> after release `rsp_valid` stays 0 and `count`=0.
